// File: rtl/wbuf_pkg.sv
// ============================================================================
// Module      : wbuf_pkg
// Description : Shared types and constants for the store write buffer.
//               The forwarding path is compiled in with WBUF_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wbuf_pkg;

  // Default configuration of the buffer
  localparam int WBUF_DEPTH_DEF = 4;
  localparam int WBUF_AW_DEF    = 32;
  localparam int WBUF_DW_DEF    = 32;

  // Drain state machine encodings
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } drain_state_t;

  // One buffered store in the default configuration. The RTL keeps entries
  // as flat vectors laid out the same way {addr, data, strb} so that AW/DW
  // stay freely parameterisable.
  typedef struct packed {
    logic [WBUF_AW_DEF-1:0]   addr;
    logic [WBUF_DW_DEF-1:0]   data;
    logic [WBUF_DW_DEF/8-1:0] strb;
  } entry_t;

endpackage : wbuf_pkg

`default_nettype wire

// File: rtl/wbuf_fifo.sv
// ============================================================================
// Module      : wbuf_fifo
// Description : Storage array, read/write pointers and occupancy counter for
//               the store write buffer. With WBUF_FWD_EN the whole array and
//               the read pointer are exported for load forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wbuf_fifo
  import wbuf_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH_DEF,
  parameter int W     = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enq,
  input  logic                        deq,
  input  logic [W-1:0]                wdata,
`ifdef WBUF_FWD_EN
  output logic [$clog2(DEPTH)-1:0]    rd_ptr,
  output logic [DEPTH-1:0][W-1:0]     slots,
`endif
  output logic [W-1:0]                peek,
  output logic [$clog2(DEPTH):0]      count,
  output logic [$clog2(DEPTH):0]      count_next,
  output logic                        full,
  output logic                        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr_adv;
  logic [W-1:0]  mem [DEPTH];

  assign count_next = count + CW'(enq) - CW'(deq);
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);

  // Entry that becomes head after this edge's dequeue (if any)
  assign rptr_adv = rptr + PW'(deq);
  assign peek     = mem[rptr_adv];

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + PW'(1);
      if (deq) rptr <= rptr_adv;
      count <= count_next;
    end
  end

  // Store data array; contents are meaningless outside [rptr, rptr+count)
  always_ff @(posedge clk) begin
    if (enq) mem[wptr] <= wdata;
  end

`ifdef WBUF_FWD_EN
  assign rd_ptr = rptr;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_slots
      assign slots[g] = mem[g];
    end
  endgenerate
`endif

endmodule : wbuf_fifo

`default_nettype wire

// File: rtl/store_write_buffer.sv
// ============================================================================
// Module      : store_write_buffer
// Description : Single-cycle store absorption between the CPU data port and
//               the memory/peripheral bus, drained with valid/ready.
//               Define WBUF_FWD_EN to merge buffered store bytes into loads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_write_buffer
  import wbuf_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH_DEF,
  parameter int AW    = WBUF_AW_DEF,
  parameter int DW    = WBUF_DW_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_we,
  input  logic [AW-1:0]            cpu_addr,
  input  logic [DW-1:0]            cpu_wdata,
  input  logic [DW/8-1:0]          cpu_wstrb,
  output logic [DW-1:0]            cpu_rdata,
  input  logic [DW-1:0]            mem_rdata,
  output logic                     bus_valid,
  input  logic                     bus_ready,
  output logic [AW-1:0]            bus_addr,
  output logic [DW-1:0]            bus_wdata,
  output logic [DW/8-1:0]          bus_wstrb,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = DW / 8;
  localparam int WW = AW - 2;          // word-address width
  localparam int EW = WW + DW + SW;    // entry layout {word_addr, data, strb}

  logic          enq;
  logic          deq;
  logic [EW-1:0] in_entry;
  logic [EW-1:0] peek;
  logic [EW-1:0] head_next;
  logic [CW-1:0] count_next;
  logic [CW-1:0] remaining;
  logic          load_head;
  logic          unused_addr_lsb;

  drain_state_t  state;
  drain_state_t  state_next;

  logic [WW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [SW-1:0] head_strb;

`ifdef WBUF_FWD_EN
  logic [PW-1:0]             rd_ptr;
  logic [DEPTH-1:0][EW-1:0]  slots;
  logic [PW-1:0]             fwd_idx;
  logic [DW-1:0]             fwd_data;
`endif

  // Byte offset never reaches the bus; stores are lane-aligned already
  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign deq      = bus_valid && bus_ready;
  assign enq      = cpu_we && (!full || deq);
  assign in_entry = {cpu_addr[AW-1:2], cpu_wdata, cpu_wstrb};

  wbuf_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .enq        (enq),
    .deq        (deq),
    .wdata      (in_entry),
`ifdef WBUF_FWD_EN
    .rd_ptr     (rd_ptr),
    .slots      (slots),
`endif
    .peek       (peek),
    .count      (count),
    .count_next (count_next),
    .full       (full),
    .empty      (empty)
  );

  // When nothing older survives this edge, the new head is the incoming store
  assign remaining = count - CW'(deq);
  assign head_next = (remaining == '0) ? in_entry : peek;

  // Drain FSM next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count_next != '0) state_next = PRESENT;
      PRESENT: if (deq && (count_next == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Head registers reload on entering PRESENT or after each transfer
  assign load_head = (state_next == PRESENT) && ((state == IDLE) || deq);

  // Drain state and registered bus head
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      head_addr <= '0;
      head_data <= '0;
      head_strb <= '0;
    end else begin
      state <= state_next;
      if (load_head) begin
        head_addr <= head_next[EW-1 -: WW];
        head_data <= head_next[SW +: DW];
        head_strb <= head_next[SW-1:0];
      end
    end
  end

  assign bus_valid = (state == PRESENT);
  assign bus_addr  = {head_addr, 2'b00};
  assign bus_wdata = head_data;
  assign bus_wstrb = head_strb;

  // Sticky drop indicator, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (cpu_we && full && !deq) begin
      overflow <= 1'b1;
    end
  end

`ifdef WBUF_FWD_EN
  // Merge buffered bytes oldest to youngest so the youngest store wins
  always_comb begin
    fwd_data = mem_rdata;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (slots[fwd_idx][EW-1 -: WW] == cpu_addr[AW-1:2])) begin
        for (int b = 0; b < SW; b++) begin
          if (slots[fwd_idx][b]) fwd_data[8*b +: 8] = slots[fwd_idx][SW + 8*b +: 8];
        end
      end
    end
  end

  assign cpu_rdata = fwd_data;
`else
  assign cpu_rdata = mem_rdata;
`endif

endmodule : store_write_buffer

`default_nettype wire
